// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared definitions for the pipelined CLA adder/subtractor.
//                Operation encodings, the per-stage control payload carried
//                down the pipeline, and a ceil-log2 helper for parameter
//                checks.
//  Options     : ADDSUB_SAT_EN (the sat field is only meaningful when set)
//  Revision    : 1.0  initial release
// ============================================================================
package cla_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Control half of a stage payload. The wide fields (partial sum and the
    // skewed A/bx operands) are width-parameterised and live beside this
    // struct in the top module.
    typedef struct packed {
        logic valid;   // stage holds a live transaction
        logic sub;     // operation, OP_ADD / OP_SUB
        logic sat;     // saturate on signed overflow
        logic carry;   // carry out of the slice resolved in this stage
    } stage_ctl_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_addsub_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : cla_addsub_pipe_if
//  Description : valid/ready bus for cla_addsub_pipe.
//                slave  : the adder/subtractor side
//                master : the producer/consumer side
//  Signals     : in_valid/in_ready/in_a/in_b/in_sub/in_cin[/in_sat]
//                out_valid/out_ready/out_sum/out_cout/out_ovf/out_zero
//  Options     : ADDSUB_SAT_EN adds in_sat
//  Revision    : 1.0  initial release
// ============================================================================
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
`ifdef ADDSUB_SAT_EN
    logic             in_sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport slave (
`ifdef ADDSUB_SAT_EN
        input  in_sat,
`endif
        input  in_valid, input in_a, input in_b, input in_sub, input in_cin,
        input  out_ready,
        output in_ready,
        output out_valid, output out_sum, output out_cout, output out_ovf,
        output out_zero
    );

    modport master (
`ifdef ADDSUB_SAT_EN
        output in_sat,
`endif
        output in_valid, output in_a, output in_b, output in_sub, output in_cin,
        output out_ready,
        input  in_ready,
        input  out_valid, input out_sum, input out_cout, input out_ovf,
        input  out_zero
    );
endinterface
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
//  Module      : cla_group
//  Description : Combinational GROUP-bit carry-lookahead adder.
//  Ports       : a, b  in  GROUP  operands
//                ci    in  1      carry in
//                s     out GROUP  sum
//                p     out 1      group propagate (all bits propagate)
//                g     out 1      group generate (carry out independent of ci)
//  Revision    : 1.0  initial release
// ============================================================================
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             p,
    output logic             g
);
    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_c;
    logic             w_term;
    logic             w_gen;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Each bit carry is a flat sum of products over g/p/ci, so no carry
    // depends on a lower carry.
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        w_gen  = 1'b0;
        w_c[0] = ci;
        for (int i = 1; i < GROUP; i++) begin
            w_term = ci;
            for (int m = 0; m < i; m++) w_term = w_term & w_p[m];
            w_c[i] = w_term;
            for (int j = 0; j < i; j++) begin
                w_term = w_g[j];
                for (int m = j + 1; m < i; m++) w_term = w_term & w_p[m];
                w_c[i] = w_c[i] | w_term;
            end
        end
        for (int j = 0; j < GROUP; j++) begin
            w_term = w_g[j];
            for (int m = j + 1; m < GROUP; m++) w_term = w_term & w_p[m];
            w_gen = w_gen | w_term;
        end
    end

    assign s = w_p ^ w_c;
    assign p = &w_p;
    assign g = w_gen;
endmodule
`default_nettype wire

// File: rtl/cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cla_addsub_pipe
//  Description : Pipelined carry-lookahead adder/subtractor, valid/ready.
//                Stage k resolves operand bits [k*W/S +: W/S]; the slice
//                carry is registered between stages and the untouched upper
//                operand bits ride along. One result per cycle, latency
//                STAGES.
//  Ports       : clk    in  clock, rising edge
//                rst_n  in  synchronous reset, active low
//                bus    slave modport of cla_addsub_pipe_if
//  Options     : ADDSUB_SAT_EN  saturate out_sum on signed overflow when
//                the transaction's in_sat is set
//  Revision    : 1.0  initial release
// ============================================================================
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cla_addsub_pipe_if.slave     bus
);
    localparam int c_SLICE_W = WIDTH / STAGES;
    localparam int c_NGRP    = c_SLICE_W / GROUP;
    localparam int c_LAST    = STAGES - 1;

    if ((WIDTH % STAGES) != 0) begin : g_chk_stages
        $error("cla_addsub_pipe: WIDTH must be a multiple of STAGES");
    end
    if (((WIDTH / STAGES) % GROUP) != 0) begin : g_chk_group
        $error("cla_addsub_pipe: slice width must be a multiple of GROUP");
    end

    // Stage registers
    stage_ctl_t       r_ctl [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_bx  [STAGES];
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    // Per-stage inputs and combinational results
    stage_ctl_t       w_ctl_in [STAGES];
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_bx_in  [STAGES];
    logic [WIDTH-1:0] w_sum_in [STAGES];
    logic [WIDTH-1:0] w_sum_nx [STAGES];
    logic             w_c_nx   [STAGES];

    logic             w_adv;
    logic             w_sat_in;

    // Whole pipe moves as one shift register; it only freezes when the
    // output holds a result nobody is taking.
    assign w_adv        = !r_ctl[c_LAST].valid || bus.out_ready;
    assign bus.in_ready = w_adv;

`ifdef ADDSUB_SAT_EN
    assign w_sat_in = bus.in_sat;
`else
    assign w_sat_in = 1'b0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [c_SLICE_W-1:0] w_s;
        logic [c_NGRP:0]      w_gc;
        logic [c_NGRP-1:0]    w_gp;
        logic [c_NGRP-1:0]    w_gg;
        logic                 w_term;
        logic [WIDTH-1:0]     w_merged;

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + ~borrow.
            assign w_ctl_in[k] = '{valid: bus.in_valid, sub: bus.in_sub,
                                   sat: w_sat_in, carry: bus.in_cin ^ bus.in_sub};
            assign w_a_in[k]   = bus.in_a;
            assign w_bx_in[k]  = bus.in_b ^ {WIDTH{bus.in_sub}};
            assign w_sum_in[k] = '0;
        end else begin : g_body
            assign w_ctl_in[k] = r_ctl[k-1];
            assign w_a_in[k]   = r_a[k-1];
            assign w_bx_in[k]  = r_bx[k-1];
            assign w_sum_in[k] = r_sum[k-1];
        end

        for (genvar j = 0; j < c_NGRP; j++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .a  (w_a_in[k][k*c_SLICE_W + j*GROUP +: GROUP]),
                .b  (w_bx_in[k][k*c_SLICE_W + j*GROUP +: GROUP]),
                .ci (w_gc[j]),
                .s  (w_s[j*GROUP +: GROUP]),
                .p  (w_gp[j]),
                .g  (w_gg[j])
            );
        end

        // Second-level lookahead: group carries from group P/G and the
        // carry entering this slice.
        always_comb begin
            w_gc    = '0;
            w_term  = 1'b0;
            w_gc[0] = w_ctl_in[k].carry;
            for (int i = 1; i <= c_NGRP; i++) begin
                w_term = w_ctl_in[k].carry;
                for (int m = 0; m < i; m++) w_term = w_term & w_gp[m];
                w_gc[i] = w_term;
                for (int j = 0; j < i; j++) begin
                    w_term = w_gg[j];
                    for (int m = j + 1; m < i; m++) w_term = w_term & w_gp[m];
                    w_gc[i] = w_gc[i] | w_term;
                end
            end
        end

        always_comb begin
            w_merged = w_sum_in[k];
            w_merged[k*c_SLICE_W +: c_SLICE_W] = w_s;
        end

        assign w_sum_nx[k] = w_merged;
        assign w_c_nx[k]   = w_gc[c_NGRP];
    end

    // Final-stage flags
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_final;
    logic             w_c_msb_in;
    logic             w_c_msb_out;
    logic             w_ovf;
    logic             w_cout;

    assign w_raw       = w_sum_nx[c_LAST];
    assign w_c_msb_out = w_c_nx[c_LAST];
    // The carry into the MSB falls out of the MSB sum bit: s = a ^ b ^ c.
    assign w_c_msb_in  = w_raw[WIDTH-1] ^ w_a_in[c_LAST][WIDTH-1] ^ w_bx_in[c_LAST][WIDTH-1];
    assign w_ovf       = w_c_msb_in ^ w_c_msb_out;
    assign w_cout      = w_c_msb_out ^ (w_ctl_in[c_LAST].sub == OP_SUB);

`ifdef ADDSUB_SAT_EN
    // On overflow both addends share A's sign, so A's MSB picks the rail.
    always_comb begin
        w_final = w_raw;
        if (w_ctl_in[c_LAST].sat && w_ovf) begin
            w_final = w_a_in[c_LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_final = w_raw;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ctl[k] <= '0;
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_bx[k]  <= '0;
            end
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ctl[k] <= '{valid: w_ctl_in[k].valid, sub: w_ctl_in[k].sub,
                              sat: w_ctl_in[k].sat, carry: w_c_nx[k]};
                r_a[k]   <= w_a_in[k];
                r_bx[k]  <= w_bx_in[k];
            end
            for (int k = 0; k < c_LAST; k++) begin
                r_sum[k] <= w_sum_nx[k];
            end
            r_sum[c_LAST] <= w_final;
            r_cout        <= w_cout;
            r_ovf         <= w_ovf;
            r_zero        <= (w_final == '0);
        end
    end

    assign bus.out_valid = r_ctl[c_LAST].valid;
    assign bus.out_sum   = r_sum[c_LAST];
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_zero  = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_addsub_pipe
//  Description : Scoreboard bench for cla_addsub_pipe (32-bit, 2 stages,
//                4-bit groups). Expected results are queued at each accepted
//                transfer and compared when the result is taken.
//  Options     : ADDSUB_SAT_EN enables the saturation vectors
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cla_addsub_pipe;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic             r_stalled = 1'b0;
    logic [WIDTH-1:0] r_held_sum;
    logic             r_held_cout;
    logic             r_held_ovf;

    cla_addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

    cla_addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .GROUP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] sum, input logic cout, input logic ovf);
        exp_t e;
        e.sum  = sum;
        e.cout = cout;
        e.ovf  = ovf;
        e.zero = (sum == '0);
        return e;
    endfunction

    // Reference: plain 33-bit arithmetic, borrow taken from the sign bit.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub, input logic cin, input logic sat);
        logic [WIDTH:0] r;
        exp_t           e;
        if (!sub) r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        else      r = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
        e.sum  = r[WIDTH-1:0];
        e.cout = r[WIDTH];
        if (!sub) e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        else      e.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
        if (sat && e.ovf) e.sum = a[WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        if (sat) e.sum = e.sum;
`endif
        e.zero = (e.sum == '0);
        return e;
    endfunction

    // Present one transaction and hold it until accepted (bounded).
    task automatic send_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sub, input logic cin, input logic sat, input exp_t e);
        int guard;
        guard        = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_cin   = cin;
`ifdef ADDSUB_SAT_EN
        bus.in_sat   = sat;
`endif
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) check("send_timeout", 64'(bus.in_ready), 64'd1);
        else               q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rnd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sub, input logic cin, input logic sat);
        send_exp(a, b, sub, cin, sat, model(a, b, sub, cin, sat));
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 64'(q.size()), 64'd0);
    endtask

    // Output monitor: scoreboard compare, stall hold and back-pressure checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            r_stalled <= 1'b0;
        end else begin
            if (r_stalled) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_sum",   64'(bus.out_sum),   64'(r_held_sum));
                check("hold_cout",  64'(bus.out_cout),  64'(r_held_cout));
                check("hold_ovf",   64'(bus.out_ovf),   64'(r_held_ovf));
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                r_stalled   <= 1'b1;
                r_held_sum  <= bus.out_sum;
                r_held_cout <= bus.out_cout;
                r_held_ovf  <= bus.out_ovf;
            end else begin
                r_stalled <= 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 64'(q.size()), 64'd1);
                end else begin
                    check("sum",  64'(bus.out_sum),  64'(q[0].sum));
                    check("cout", 64'(bus.out_cout), 64'(q[0].cout));
                    check("ovf",  64'(bus.out_ovf),  64'(q[0].ovf));
                    check("zero", 64'(bus.out_zero), 64'(q[0].zero));
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_cin    = 1'b0;
`ifdef ADDSUB_SAT_EN
        bus.in_sat    = 1'b0;
`endif
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_sum",   64'(bus.out_sum),   64'd0);
        check("rst_out_cout",  64'(bus.out_cout),  64'd0);
        check("rst_out_ovf",   64'(bus.out_ovf),   64'd0);
        check("rst_out_zero",  64'(bus.out_zero),  64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Wrap to zero, with latency measured on an empty pipe
        send_exp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0));
        idle();
        for (int i = 0; i < STAGES - 1; i++) begin
            @(negedge clk);
            check("lat_early_valid", 64'(bus.out_valid), 64'd0);
        end
        @(negedge clk);
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back to back
        send_exp(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
        send_exp(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0, mk(32'hFFFF_FFFE, 1'b1, 1'b0));
        send_exp(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0));
        send_exp(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, mk(32'hFFFF_FFFF, 1'b1, 1'b0));
        send_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1));
        send_exp(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, mk(32'h0001_0000, 1'b0, 1'b0));
        idle();
        wait_drain();

        // Eight-transfer stream with a three-cycle output stall
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_rnd(32'h1000_0000 * i + i, 32'h0F00_0003 * i, i[0], i[1], 1'b0);
                end
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();

        // Random traffic with input bubbles and random back-pressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                    send_rnd($urandom, $urandom, 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                idle();
            end
            begin
                repeat (70) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();

        // Reset with two transactions in flight
        send_exp(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, mk(32'h2345_6789, 1'b0, 1'b0));
        send_exp(32'h0000_0010, 32'h0000_0001, 1'b1, 1'b0, 1'b0, mk(32'h0000_000F, 1'b0, 1'b0));
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("postrst_in_ready",  64'(bus.in_ready),  64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_no_stale", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Saturation / wrap on signed overflow
`ifdef ADDSUB_SAT_EN
        send_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
        send_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1));
        send_exp(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, mk(32'h8000_0000, 1'b0, 1'b1));
        send_exp(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, mk(32'h8000_0000, 1'b1, 1'b1));
`else
        send_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, mk(32'h8000_0000, 1'b0, 1'b1));
        send_exp(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b1));
`endif
        idle();
        wait_drain();

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
